// File: rtl/mips_cp0.sv
// MIPS coprocessor 0: Status/Cause/EPC plus general MTC0/MFC0 storage,
// SYSCALL/BREAK/TEQ exception entry and ERET return.
module mips_cp0 #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        teq,
  input  logic        eret,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic [31:0] pc,
  input  logic [4:0]  addr,
  input  logic [4:0]  cause,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] exc_addr
);

  typedef enum logic [4:0] {
    EXC_SYSCALL = 5'b01000,
    EXC_BREAK   = 5'b01001,
    EXC_TEQ     = 5'b01101
  } exc_code_e;

  localparam int unsigned REG_STATUS = 12;
  localparam int unsigned REG_CAUSE  = 13;
  localparam int unsigned REG_EPC    = 14;

  logic [31:0] regs [32];
  logic [31:0] status;
  logic        exception;

  assign status = regs[REG_STATUS];

  always_comb begin
    exception = status[0] &
                ((cause == EXC_SYSCALL & status[1]) |
                 (cause == EXC_BREAK   & status[2]) |
                 (cause == EXC_TEQ & teq & status[3]));
  end

  // Left shift on entry clears the enables so a held cause code is taken once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      regs[REG_STATUS] <= STATUS_RST;
    end else if (eret) begin
      regs[REG_STATUS] <= status >> 5;
    end else if (exception) begin
      regs[REG_EPC]    <= pc;
      regs[REG_CAUSE]  <= {regs[REG_CAUSE][31:7], cause, 2'b00};
      regs[REG_STATUS] <= status << 5;
    end else if (mtc0) begin
      regs[addr] <= wdata;
    end
  end

  assign rdata    = mfc0 ? regs[addr] : '0;
  assign exc_addr = eret ? regs[REG_EPC] : EXC_VECTOR;

endmodule

// File: tb/tb_mips_cp0.sv
// Scoreboard bench for mips_cp0: a reference model predicts register state;
// expected read/redirect values are queued at drive time and popped on sample.
module tb_mips_cp0;

  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
  localparam logic [31:0] STATUS_RST = 32'h0000_000F;

  logic        clk;
  logic        rst;
  logic        teq;
  logic        eret;
  logic        mtc0;
  logic        mfc0;
  logic [31:0] pc;
  logic [4:0]  addr;
  logic [4:0]  cause;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] exc_addr;

  mips_cp0 #(.EXC_VECTOR(EXC_VECTOR), .STATUS_RST(STATUS_RST)) dut (
    .clk(clk), .rst(rst), .teq(teq), .eret(eret), .mtc0(mtc0), .mfc0(mfc0),
    .pc(pc), .addr(addr), .cause(cause), .wdata(wdata),
    .rdata(rdata), .exc_addr(exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] sb [$];
  logic [31:0] m [32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic w, input logic t,
                            input logic [4:0] c, input logic [31:0] p,
                            input logic [4:0] a, input logic [31:0] d);
    logic exc;
    logic [31:0] st;
    st  = m[12];
    exc = st[0] & ((c == 5'b01000 & st[1]) | (c == 5'b01001 & st[2]) |
                   (c == 5'b01101 & t & st[3]));
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      m[12] = STATUS_RST;
    end else if (e) begin
      m[12] = st >> 5;
    end else if (exc) begin
      m[14] = p;
      m[13] = {m[13][31:7], c, 2'b00};
      m[12] = st << 5;
    end else if (w) begin
      m[a] = d;
    end
  endtask

  // One clock: drive at negedge, check exc_addr before the edge, advance model.
  task automatic cycle(input logic r, input logic e, input logic w, input logic t,
                       input logic [4:0] c, input logic [31:0] p,
                       input logic [4:0] a, input logic [31:0] d);
    rst = r; eret = e; mtc0 = w; teq = t; cause = c; pc = p; addr = a; wdata = d;
    mfc0 = 1'b0;
    if (!r) begin
      sb.push_back(e ? m[14] : EXC_VECTOR);
      #1;
      check("exc_addr", exc_addr, sb.pop_front());
    end
    @(posedge clk);
    model_edge(r, e, w, t, c, p, a, d);
    @(negedge clk);
    rst = 1'b0; eret = 1'b0; mtc0 = 1'b0; teq = 1'b0; cause = '0; pc = '0; wdata = '0;
  endtask

  task automatic read_model(input string tag, input logic [4:0] a);
    mfc0 = 1'b1; addr = a;
    sb.push_back(m[a]);
    #1;
    check(tag, rdata, sb.pop_front());
    mfc0 = 1'b0;
  endtask

  task automatic read_const(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0 = 1'b1; addr = a;
    sb.push_back(exp);
    #1;
    check(tag, rdata, sb.pop_front());
    mfc0 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; teq = 1'b0; eret = 1'b0; mtc0 = 1'b0; mfc0 = 1'b0;
    pc = '0; addr = '0; cause = '0; wdata = '0;
    for (int i = 0; i < 32; i++) m[i] = 'x;
    @(negedge clk);

    cycle(1, 0, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0);
    read_const("rst_status", 5'd12, 32'h0000_000F);
    read_const("rst_cause", 5'd13, 32'h0);
    read_const("rst_epc", 5'd14, 32'h0);
    addr = 5'd12; mfc0 = 1'b0;
    #1; check("mfc0_off", rdata, 32'h0);

    cycle(0, 0, 1, 0, 5'd0, 32'd0, 5'd2, 32'hF);
    read_const("mtc0_r2", 5'd2, 32'h0000_000F);

    cycle(0, 0, 0, 0, 5'b01000, 32'd3, 5'd0, 32'd0);
    read_const("sys_status", 5'd12, 32'h0000_01E0);
    read_const("sys_cause", 5'd13, 32'h0000_0020);
    read_const("sys_epc", 5'd14, 32'h0000_0003);
    cycle(0, 0, 0, 0, 5'b01000, 32'd7, 5'd0, 32'd0);
    cycle(0, 0, 0, 0, 5'b01000, 32'd8, 5'd0, 32'd0);
    read_const("hold_status", 5'd12, 32'h0000_01E0);
    read_const("hold_cause", 5'd13, 32'h0000_0020);
    read_const("hold_epc", 5'd14, 32'h0000_0003);

    cycle(0, 1, 0, 0, 5'b01000, 32'd5, 5'd0, 32'd0);
    read_const("eret_status", 5'd12, 32'h0000_000F);
    read_const("eret_epc", 5'd14, 32'h0000_0003);

    cycle(0, 0, 0, 0, 5'b01001, 32'd4, 5'd0, 32'd0);
    read_const("brk_cause", 5'd13, 32'h0000_0024);
    read_const("brk_epc", 5'd14, 32'h0000_0004);
    cycle(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0);
    cycle(0, 0, 0, 1, 5'b01101, 32'd2, 5'd0, 32'd0);
    read_const("teq_cause", 5'd13, 32'h0000_0034);
    read_const("teq_epc", 5'd14, 32'h0000_0002);
    cycle(0, 1, 0, 0, 5'd0, 32'd0, 5'd0, 32'd0);
    cycle(0, 0, 0, 0, 5'b01101, 32'd9, 5'd0, 32'd0);
    read_const("teq0_status", 5'd12, 32'h0000_000F);
    read_const("teq0_cause", 5'd13, 32'h0000_0034);
    read_const("teq0_epc", 5'd14, 32'h0000_0002);

    cycle(0, 0, 1, 0, 5'd0, 32'd0, 5'd12, 32'h1);
    cycle(0, 0, 0, 0, 5'b01000, 32'd1, 5'd0, 32'd0);
    read_const("mask_status", 5'd12, 32'h0000_0001);
    read_const("mask_cause", 5'd13, 32'h0000_0034);
    read_const("mask_epc", 5'd14, 32'h0000_0002);

    cycle(0, 0, 1, 0, 5'd0, 32'd0, 5'd12, 32'hF);
    cycle(0, 1, 1, 0, 5'b01001, 32'd6, 5'd5, 32'hAA);
    read_const("pri_status", 5'd12, 32'h0000_0000);
    read_const("pri_cause", 5'd13, 32'h0000_0034);
    read_const("pri_epc", 5'd14, 32'h0000_0002);
    read_const("pri_eret_mtc0", 5'd5, 32'h0);
    cycle(0, 0, 1, 0, 5'd0, 32'd0, 5'd12, 32'hF);
    cycle(0, 0, 1, 0, 5'b01000, 32'd11, 5'd5, 32'hBB);
    read_const("pri_exc_mtc0", 5'd5, 32'h0);
    read_const("pri_exc_epc", 5'd14, 32'h0000_000B);

    for (int n = 0; n < 60; n++) begin
      logic [4:0] c;
      case ($urandom_range(3))
        0: c = 5'b01000;
        1: c = 5'b01001;
        2: c = 5'b01101;
        default: c = 5'($urandom);
      endcase
      cycle(($urandom_range(29) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
            1'($urandom), c, $urandom, ($urandom_range(1) == 0) ? 5'd12 : 5'($urandom),
            ($urandom_range(1) == 0) ? 32'hF : $urandom);
      read_model("rand_rd", 5'($urandom));
      read_model("rand_status", 5'd12);
    end

    cycle(0, 0, 1, 0, 5'd0, 32'd0, 5'd2, 32'h1234);
    cycle(1, 0, 1, 0, 5'b01000, 32'd9, 5'd3, 32'h55);
    read_const("rst2_status", 5'd12, 32'h0000_000F);
    read_const("rst2_cause", 5'd13, 32'h0);
    read_const("rst2_epc", 5'd14, 32'h0);
    read_const("rst2_r2", 5'd2, 32'h0);
    read_const("rst2_r3", 5'd3, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cp0.md
Name: mips_cp0

Overview:
Coprocessor 0 for the single-cycle 54-instruction MIPS CPU. It holds the Status (reg 12), Cause (reg 13) and EPC (reg 14) registers. It services MFC0/MTC0, takes SYSCALL, BREAK and TEQ exceptions, and executes ERET. It sits beside the regfile; the datapath uses exc_addr as the next PC on exception or ERET.

Parameters:
EXC_VECTOR, 32'h00400004, exception handler entry address driven on exc_addr when not ERET
STATUS_RST, 32'h0000000F, Status reset value (IE and all three cause enables set)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
teq  in  1  TEQ compare true (rs==rt) this cycle; qualifies cause code TEQ
eret  in  1  ERET instruction executing this cycle
mtc0  in  1  write wdata to CP0 reg[addr] at clock edge
mfc0  in  1  read enable for rdata
pc  in  32  address of current instruction; captured into EPC on exception
addr  in  5  CP0 register number (rd field)
cause  in  5  exception code from decoder: 5'b01000 SYSCALL, 5'b01001 BREAK, 5'b01101 TEQ, any other value = no exception
wdata  in  32  MTC0 write data (rt value)
rdata  out  32  MFC0 read data
exc_addr  out  32  redirect PC: EPC during eret, else EXC_VECTOR

Behaviour:
- Storage: 32 x 32-bit registers; only 12/13/14 have special semantics. The others are plain MTC0/MFC0 storage.
- Reset (rst=1 at posedge): all regs 0 except Status = STATUS_RST. rst overrides every other input.
- Status bits: [0] IE global enable; [1] SYSCALL enable; [2] BREAK enable; [3] TEQ enable.
- exception = Status[0] & ((cause==SYSCALL & Status[1]) | (cause==BREAK & Status[2]) | (cause==TEQ & teq & Status[3])).
- cause==TEQ with teq=0 is not an exception.
- On exception (posedge, no rst, no eret):
  - EPC <= pc
  - Cause <= {Cause[31:7], cause, 2'b00}
  - Status <= Status << 5
  - The shift clears bits[3:0], which masks nested exceptions. A cause code held for several cycles is therefore taken only once.
- On eret (posedge, no rst): Status <= Status >> 5 (restores prior enables). EPC and Cause are unchanged.
- Priority at an edge: rst > eret > exception > mtc0.
  - An MTC0 in the same cycle as an exception or eret is discarded.
  - eret together with a valid cause code: eret wins and no exception is taken.
- mtc0 alone: reg[addr] <= wdata. This includes Status, Cause and EPC, which are fully writable.
- rdata: combinational; mfc0 ? reg[addr] : 32'h0. It reflects the register value after the most recent edge, so there is no write-through bypass.
- exc_addr: combinational; eret ? EPC : EXC_VECTOR. The CPU selects it only on exception or eret.
- Latency: all state changes become visible on the cycle after the edge; there is no handshake.
- Masked exception (enable bit 0): no state change and no register side effects.

Test Plan:
- Reset → mfc0=1: addr=12 reads 0x0000000F; addr=13 and addr=14 read 0x00000000. With mfc0=0, rdata=0.
- MTC0 then MFC0: mtc0=1, addr=2, wdata=0xF for one edge; then mfc0=1, addr=2 → rdata=0x0000000F.
- SYSCALL taken: cause=01000, pc=3, one edge.
  - Status reads 0x000001E0, Cause reads 0x00000020, EPC reads 0x00000003; exc_addr=0x00400004.
  - Holding cause for more edges leaves all three registers unchanged.
- ERET after SYSCALL: eret=1, cause=01000, pc=5 → exc_addr=0x00000003 combinationally. After the edge Status=0x0000000F and EPC is still 3, so no new exception was taken.
- BREAK, then TEQ:
  - cause=01001, pc=4 → Cause=0x00000024, EPC=4.
  - After eret: cause=01101, teq=1, pc=2 → Cause=0x00000034, EPC=2.
  - cause=01101, teq=0 → no change.
- Masking: MTC0 Status=0x00000001, then cause=01000, pc=1 → Status, Cause and EPC unchanged.
- Priority: eret=1 with cause=01001 → only Status>>5 occurs.
- Reset mid-operation: rst with an exception pending → regs restored to their reset values.
